// File: rtl/conv_frame_ctrl_if.sv
// Memory read port and convolution-core side of the frame sequencer.
// master = sequencer, slave = memory / convolution core.
interface conv_frame_ctrl_if #(
    parameter int AW   = 14,
    parameter int P    = 4,
    parameter int BITW = 8
);
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [P*BITW-1:0] rd_data;
    logic              conv_in_valid;
    logic [P*BITW-1:0] conv_in_pix_vec;
    logic [71:0]       conv_kern;
    logic [P-1:0]      conv_out_valid_vec;

    modport master (
        output rd_en, rd_addr, conv_in_valid,
        output conv_in_pix_vec, conv_kern,
        input  rd_data, conv_out_valid_vec
    );

    modport slave (
        input  rd_en, rd_addr, conv_in_valid,
        input  conv_in_pix_vec, conv_kern,
        output rd_data, conv_out_valid_vec
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the P-lane conv datapath: stream, drain, done.
// Optional frame output-count check: define CONV_FRAME_CHECK_EN.
module conv_frame_ctrl #(
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int BITW      = 8,
    parameter int P         = 4,
    parameter int AW        = 14,
    parameter int DRAIN_CYC = 80,
    parameter int CW        = 20
`ifdef CONV_FRAME_CHECK_EN
    ,
    parameter int EXP_OUT   = WIDTH * HEIGHT
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    input  logic [71:0]   kern_cfg,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] out_cnt,
    output logic          frame_err,
    conv_frame_ctrl_if.master bus
);

    localparam int NW = WIDTH * HEIGHT / P;
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int PW = $clog2(P + 1);
    localparam logic [AW-1:0] LAST = AW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [DW-1:0] dcnt;
    logic [PW-1:0] pc;
    logic [CW:0]   sum;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        pc = '0;
        for (int i = 0; i < P; i++) begin
            pc = pc + PW'(bus.conv_out_valid_vec[i]);
        end
    end

    // Saturating lane count including this cycle's valid lanes.
    always_comb begin
        sum     = {1'b0, out_cnt} + (CW+1)'(pc);
        cnt_nxt = sum[CW] ? '1 : sum[CW-1:0];
    end

    assign busy  = (state != IDLE);
    assign done  = (state == S_DONE);
    assign bus.rd_en = (state == STREAM) && !stall;
    assign bus.conv_in_pix_vec = bus.rd_data;

`ifdef CONV_FRAME_CHECK_EN
    logic err;
    assign frame_err = err;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            dcnt              <= '0;
            bus.rd_addr       <= '0;
            bus.conv_in_valid <= 1'b0;
            bus.conv_kern     <= '0;
            out_cnt           <= '0;
`ifdef CONV_FRAME_CHECK_EN
            err               <= 1'b0;
`endif
        end else begin
            bus.conv_in_valid <= bus.rd_en;
            if (busy) out_cnt <= cnt_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bus.conv_kern <= kern_cfg;
                        out_cnt       <= '0;
                        bus.rd_addr   <= '0;
                        state         <= STREAM;
`ifdef CONV_FRAME_CHECK_EN
                        err           <= 1'b0;
`endif
                    end
                end
                STREAM: begin
                    // Address freezes on the last word until the next start.
                    if (bus.rd_en) begin
                        if (bus.rd_addr == LAST) begin
                            state <= DRAIN;
                            dcnt  <= DW'(DRAIN_CYC - 1);
                        end else begin
                            bus.rd_addr <= bus.rd_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == '0) state <= S_DONE;
                    else            dcnt  <= dcnt - 1'b1;
                end
                S_DONE: begin
                    state <= IDLE;
`ifdef CONV_FRAME_CHECK_EN
                    err   <= (cnt_nxt != CW'(EXP_OUT));
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl: 8x4 frame, P=4, 4 drain cycles.
// Honours CONV_FRAME_CHECK_EN with EXP_OUT=32.
module tb_conv_frame_ctrl;

    localparam logic [71:0] SOBEL = 72'h01_00_FF_02_00_FE_01_00_FF;
    localparam logic [71:0] K7F   = {9{8'h7F}};
`ifdef CONV_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [71:0] kern_cfg;
    logic        busy, done, frame_err;
    logic [19:0] out_cnt;
    logic [31:0] mem [16];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_frame_ctrl_if #(.AW(4), .P(4), .BITW(8)) bif ();

    conv_frame_ctrl #(
        .WIDTH(8), .HEIGHT(4), .BITW(8), .P(4),
        .AW(4), .DRAIN_CYC(4), .CW(20)
`ifdef CONV_FRAME_CHECK_EN
        , .EXP_OUT(32)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .kern_cfg(kern_cfg), .busy(busy), .done(done),
        .out_cnt(out_cnt), .frame_err(frame_err), .bus(bif)
    );

    function automatic logic [31:0] word(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Synchronous frame memory, 1-cycle read latency.
    always @(posedge clk) begin
        if (bif.rd_en) bif.rd_data <= mem[bif.rd_addr];
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        bif.conv_out_valid_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        kern_cfg = SOBEL;
        do_reset();
        #1;
        total++;
        if ({busy, done, bif.rd_en, bif.conv_in_valid, frame_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b want 00000",
                {busy, done, bif.rd_en, bif.conv_in_valid, frame_err});
        end
        total++;
        if (bif.rd_addr !== 4'd0 || out_cnt !== 20'd0) begin
            bad++;
            $display("FAIL reset_cnt addr=%0d cnt=%0d want 0 0",
                bif.rd_addr, out_cnt);
        end
        total++;
        if (bif.conv_kern !== 72'd0) begin
            bad++;
            $display("FAIL reset_kern got %h want 0", bif.conv_kern);
        end
    endtask

    task automatic test_basic();
        logic e_en, e_v, e_busy, e_done;
        do_reset();
        kern_cfg = SOBEL;
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            adv();
            start = 1'b0;
            #1;
            e_en   = (c >= 1 && c <= 8);
            e_v    = (c >= 2 && c <= 9);
            e_busy = (c <= 13);
            e_done = (c == 13);
            total++;
            if ({bif.rd_en, bif.conv_in_valid, busy, done} !==
                {e_en, e_v, e_busy, e_done}) begin
                bad++;
                $display("FAIL basic_ctl c=%0d got %b want %b", c,
                    {bif.rd_en, bif.conv_in_valid, busy, done},
                    {e_en, e_v, e_busy, e_done});
            end
            total++;
            if (bif.rd_addr !== (e_en ? 4'(c - 1) : 4'd7)) begin
                bad++;
                $display("FAIL basic_addr c=%0d got %0d", c, bif.rd_addr);
            end
            if (e_v) begin
                total++;
                if (bif.conv_in_pix_vec !== word(c - 2)) begin
                    bad++;
                    $display("FAIL basic_pix c=%0d got %h want %h", c,
                        bif.conv_in_pix_vec, word(c - 2));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic e_en, e_v, prev;
        int iss = 0;
        int vi  = 0;
        do_reset();
        start = 1'b1;
        prev  = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            adv();
            start = 1'b0;
            stall = (c == 3 || c == 4);
            #1;
            e_en = (c <= 10) && !(c == 3 || c == 4);
            e_v  = prev;
            total++;
            if ({bif.rd_en, bif.conv_in_valid, busy, done} !==
                {e_en, e_v, c <= 15, c == 15}) begin
                bad++;
                $display("FAIL stall_ctl c=%0d got %b", c,
                    {bif.rd_en, bif.conv_in_valid, busy, done});
            end
            if (e_en) begin
                total++;
                if (bif.rd_addr !== 4'(iss)) begin
                    bad++;
                    $display("FAIL stall_addr c=%0d got %0d want %0d",
                        c, bif.rd_addr, iss);
                end
                iss++;
            end
            if (e_v) begin
                total++;
                if (bif.conv_in_pix_vec !== word(vi)) begin
                    bad++;
                    $display("FAIL stall_pix c=%0d got %h want %h", c,
                        bif.conv_in_pix_vec, word(vi));
                end
                vi++;
            end
            prev = e_en;
        end
        stall = 1'b0;
    endtask

    task automatic test_kernel();
        int nd = 0;
        do_reset();
        kern_cfg = SOBEL;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            adv();
            start = (c == 2 || c == 5);
            if (c >= 3) kern_cfg = K7F;
            #1;
            if (done === 1'b1) nd++;
            total++;
            if (bif.conv_kern !== SOBEL) begin
                bad++;
                $display("FAIL kern_hold c=%0d got %h want %h", c,
                    bif.conv_kern, SOBEL);
            end
        end
        total++;
        if (nd != 1) begin
            bad++;
            $display("FAIL kern_done_cnt got %0d want 1", nd);
        end
        start = 1'b1;
        adv();
        start = 1'b0;
        #1;
        total++;
        if (bif.conv_kern !== K7F || busy !== 1'b1) begin
            bad++;
            $display("FAIL kern_new got %h busy=%b want %h busy=1",
                bif.conv_kern, busy, K7F);
        end
    endtask

    task automatic test_out_cnt();
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            adv();
            start = 1'b0;
            bif.conv_out_valid_vec = (c >= 2 && c <= 9) ? 4'hF :
                                     (c == 10 || c == 15) ? 4'h3 : 4'h0;
            if (c == 15) bif.conv_out_valid_vec = 4'hF;
            #1;
            if (c == 14 || c == 16) begin
                total++;
                if (out_cnt !== 20'd34 || frame_err !== CHK) begin
                    bad++;
                    $display("FAIL cnt34 c=%0d got %0d err=%b want 34 err=%b",
                        c, out_cnt, frame_err, CHK);
                end
            end
        end
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            adv();
            start = 1'b0;
            bif.conv_out_valid_vec =
                ((c >= 2 && c <= 8) || c == 13) ? 4'hF : 4'h0;
            #1;
            if (c == 1) begin
                total++;
                if (out_cnt !== 20'd0 || frame_err !== 1'b0) begin
                    bad++;
                    $display("FAIL cnt_clr got %0d err=%b want 0 err=0",
                        out_cnt, frame_err);
                end
            end
            if (c == 14) begin
                total++;
                if (out_cnt !== 20'd32 || frame_err !== 1'b0) begin
                    bad++;
                    $display("FAIL cnt32 got %0d err=%b want 32 err=0",
                        out_cnt, frame_err);
                end
            end
        end
        bif.conv_out_valid_vec = '0;
    endtask

    task automatic test_midrst();
        int nd = 0;
        do_reset();
        kern_cfg = K7F;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            adv();
            start = 1'b0;
            rst = (c == 6);
            #1;
        end
        adv();
        rst = 1'b0;
        #1;
        total++;
        if ({busy, bif.rd_en, bif.conv_in_valid, done} !== 4'b0) begin
            bad++;
            $display("FAIL midrst_ctl got %b want 0000",
                {busy, bif.rd_en, bif.conv_in_valid, done});
        end
        total++;
        if (bif.rd_addr !== 4'd0 || bif.conv_kern !== 72'd0) begin
            bad++;
            $display("FAIL midrst_state addr=%0d kern=%h want 0 0",
                bif.rd_addr, bif.conv_kern);
        end
        for (int c = 0; c < 14; c++) begin
            adv();
            #1;
            if (done === 1'b1) nd++;
        end
        total++;
        if (nd != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_nodone dones=%0d busy=%b want 0 0", nd, busy);
        end
        start = 1'b1;
        adv();
        start = 1'b0;
        #1;
        total++;
        if (bif.rd_en !== 1'b1 || bif.rd_addr !== 4'd0) begin
            bad++;
            $display("FAIL midrst_restart en=%b addr=%0d want 1 0",
                bif.rd_en, bif.rd_addr);
        end
        adv();
        #1;
        total++;
        if (bif.conv_in_valid !== 1'b1 || bif.conv_in_pix_vec !== word(0)) begin
            bad++;
            $display("FAIL midrst_word v=%b got %h want %h",
                bif.conv_in_valid, bif.conv_in_pix_vec, word(0));
        end
    endtask

    task automatic test_back_to_back();
        logic e_busy, e_done;
        do_reset();
        bif.conv_out_valid_vec = 4'b0001;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            adv();
            #1;
            e_busy = (c <= 13) || (c >= 15 && c <= 27) || (c >= 29);
            e_done = (c == 13 || c == 27);
            total++;
            if ({busy, done} !== {e_busy, e_done}) begin
                bad++;
                $display("FAIL b2b_ctl c=%0d got %b want %b", c,
                    {busy, done}, {e_busy, e_done});
            end
            if (c == 14 || c == 15 || c == 16) begin
                total++;
                if (out_cnt !== (c == 14 ? 20'd13 : 20'(c - 15))) begin
                    bad++;
                    $display("FAIL b2b_cnt c=%0d got %0d", c, out_cnt);
                end
            end
            if (c == 15) begin
                total++;
                if (bif.rd_en !== 1'b1 || bif.rd_addr !== 4'd0) begin
                    bad++;
                    $display("FAIL b2b_restart en=%b addr=%0d want 1 0",
                        bif.rd_en, bif.rd_addr);
                end
            end
        end
        start = 1'b0;
        bif.conv_out_valid_vec = '0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = word(i);
        bif.rd_data = '0;
        bif.conv_out_valid_vec = '0;
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        kern_cfg = '0;
        test_reset();
        test_basic();
        test_stall();
        test_kernel();
        test_out_cnt();
        test_midrst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
Frame sequencer for the P-lane 2D convolution datapath (Top_conv_p). On a start pulse it latches the 3x3 kernel, then streams one WIDTH x HEIGHT frame in raster order from a synchronous pixel memory, P pixels per word. Words go to the convolution input, with optional stall. After the frame it drains the convolution pipeline and pulses done. It sits between the system/CPU control side, the frame memory and the convolution core.

Parameters:
WIDTH, 256, frame width in pixels; must be a multiple of P
HEIGHT, 256, frame height in rows
BITW, 8, bits per pixel
P, 4, pixels per word/cycle (1, 2 or 4)
AW, 14, memory word-address width; must satisfy 2^AW >= WIDTH*HEIGHT/P
DRAIN_CYC, 80, cycles held in DRAIN after the last word is issued (>= WIDTH/P + CONV_LAT + margin)
CW, 20, width of the output-lane counter

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin frame; sampled only in IDLE
stall  in  1  1 = suspend memory reads (no new word issued this cycle)
kern_cfg  in  72  packed signed 8-bit taps {k22,k21,k20,k12,k11,k10,k02,k01,k00}; k00 in [7:0]
busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive
done  out  1  one-cycle pulse at end of frame
rd_en  out  1  memory read strobe
rd_addr  out  AW  memory word address
rd_data  in  P*BITW  memory read data, valid 1 cycle after rd_en; lane 0 in the LSBs
conv_in_valid  out  1  convolution input valid
conv_in_pix_vec  out  P*BITW  convolution input word
conv_kern  out  72  kernel taps driven to the convolution core; stable while busy
conv_out_valid_vec  in  P  per-lane output valid from the convolution core
out_cnt  out  CW  number of valid output lanes seen in the current or last frame
frame_err  out  1  see Optional Feature

Behaviour:
- Reset (sync, rst=1): state=IDLE. busy, done, rd_en, conv_in_valid = 0. rd_addr, conv_kern, out_cnt, frame_err = 0. Reset mid-frame aborts immediately, with no done pulse.
- Constant NW = WIDTH*HEIGHT/P.
- IDLE: busy=0. When start=1: latch kern_cfg into conv_kern, clear out_cnt and frame_err, set rd_addr=0, go to STREAM.
- STREAM: busy=1.
  - rd_en = ~stall.
  - When rd_en=1: rd_addr increments next cycle.
  - When rd_en=1 and rd_addr==NW-1: go to DRAIN, load the drain counter with DRAIN_CYC-1.
  - When stall=1: rd_addr holds and no word is issued.
- DRAIN: busy=1, rd_en=0. Counter decrements each cycle (stall ignored). At 0 go to DONE.
- DONE: busy=1 and done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored; start is accepted no earlier than the following IDLE cycle.
- start while busy is ignored. kern_cfg changes while busy do not affect conv_kern.
- conv_in_valid is rd_en registered (1-cycle delay), cleared by reset. conv_in_pix_vec = rd_data (combinational passthrough), and is meaningful only when conv_in_valid=1.
- Latency: start sampled at cycle 0 gives rd_en=1 / addr 0 at cycle 1, and conv_in_valid=1 with word 0 at cycle 2. With no stall, the frame occupies NW consecutive conv_in_valid cycles.
- out_cnt: each cycle that busy=1, add popcount(conv_out_valid_vec). Saturates at 2^CW-1. Held after DONE until the next accepted start. Outputs with busy=0 are ignored.
- rd_addr wraps never: it is frozen at NW-1 after the last issue until the next start resets it to 0.

Optional Feature:
Macro CONV_FRAME_CHECK_EN.
- Defined: adds parameter EXP_OUT (default WIDTH*HEIGHT). In the DONE cycle, frame_err is registered as (out_cnt_final != EXP_OUT), where out_cnt_final includes lanes valid in the DONE cycle itself. frame_err holds until the next accepted start or reset.
- Not defined: frame_err tied to 0, no comparator.

Test Plan:
1. WIDTH=8, HEIGHT=4, P=4 (NW=8), DRAIN_CYC=4, no stall, start at cycle 0 -> rd_en high cycles 1-8 with addr 0..7; conv_in_valid cycles 2-9 carrying memory words 0..7; DRAIN cycles 9-12; done=1 at cycle 13 only; busy high cycles 1-13.
2. Same config, stall=1 during cycles 3-4 -> addr 2 issued at cycle 5; conv_in_valid low at cycles 4-5; last word issued at cycle 10; done at cycle 15; word order unchanged.
3. kern_cfg=Sobel X at start, changed to all-0x7F at cycle 3 -> conv_kern keeps the Sobel X value until the next start; start pulses at cycles 2 and 5 are ignored (single done).
4. Model conv_out_valid_vec=4'b1111 for 8 cycles plus 4'b0011 once while busy -> out_cnt=34 after done. With CONV_FRAME_CHECK_EN and EXP_OUT=32: frame_err=1. With 8 full cycles only: out_cnt=32, frame_err=0.
5. rst=1 at cycle 6 mid-STREAM -> next cycle busy=0, rd_en=0, conv_in_valid=0, no done; a new start then restarts from addr 0.
6. start held high continuously -> back-to-back frames separated by at least one IDLE cycle; out_cnt cleared at each accepted start.
